// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory sequencing controller.
//   - Default geometry (word-index width, instruction width, starve limit)
//   - Controller phase enum (LOAD, RUN)
//   - Read-response source tag enum (SRC_IF, SRC_DBG)
// -----------------------------------------------------------------------------
package imem_pkg;

  localparam int ADDR_W_DEF     = 11;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } imem_state_e;

  typedef enum logic {
    SRC_IF  = 1'b0,
    SRC_DBG = 1'b1
  } imem_src_e;

endpackage

// File: rtl/imem_rr_guard.sv
// -----------------------------------------------------------------------------
// imem_rr_guard
// Fetch-priority arbiter with a starvation guard for the debug read port.
// Fetch wins a contested cycle until the debug port has lost STARVE_MAX
// consecutive contested cycles; the next contested cycle goes to debug.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   en             arbitration enabled (controller in RUN)
//   if_req         fetch request
//   dbg_req        debug read request
//   if_win         fetch granted this cycle (combinational)
//   dbg_win        debug granted this cycle (combinational)
//   starve_cnt     consecutive contested losses of the debug port
// -----------------------------------------------------------------------------
module imem_rr_guard #(
  parameter int STARVE_MAX = 4,
  parameter int SW         = $clog2(STARVE_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          if_req,
  input  logic          dbg_req,
  output logic          if_win,
  output logic          dbg_win,
  output logic [SW-1:0] starve_cnt
);

  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [SW-1:0] starve_nxt;

  // The counter only survives a cycle in which debug asked and lost;
  // any debug grant or idle debug request clears it.
  always_comb begin
    if_win     = 1'b0;
    dbg_win    = 1'b0;
    starve_nxt = '0;
    if (en) begin
      if (if_req && dbg_req) begin
        if (starve_cnt == STARVE_LIM) begin
          dbg_win = 1'b1;
        end else begin
          if_win     = 1'b1;
          starve_nxt = starve_cnt + SW'(1);
        end
      end else if (if_req) begin
        if_win = 1'b1;
      end else if (dbg_req) begin
        dbg_win = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_nxt;
    end
  end

endmodule

// File: rtl/imem_ctrl.sv
// -----------------------------------------------------------------------------
// imem_ctrl
// Sequencing controller for the single-port instruction memory bank.
// After reset it boot-loads the bank from the loader port (LOAD), then hands
// the bank to the fetch stage and a debug read port (RUN).
//
// Optional feature macro: IMEM_CTRL_ALIGN_CHK_EN
//   defined   -> granted fetch with if_addr[1:0] != 0 sets sticky if_misalign
//   undefined -> if_misalign tied low
//
// Handshake: a loader word transfers on a rising clk edge where ld_valid and
// ld_ready are both high; ld_ready does not depend on ld_valid. The read ports
// are request/grant: a grant is combinational from the request in the same
// cycle and the data returns with rvalid exactly one cycle later.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   ld_valid/ld_data/ld_last   loader stream in, ld_ready out
//   if_req/if_addr             fetch request (byte address)
//   if_gnt/if_rvalid/if_rdata  fetch grant and response
//   dbg_req/dbg_addr           debug read request (word index)
//   dbg_gnt/dbg_rvalid/dbg_rdata debug grant and response
//   mem_we/mem_re/mem_addr/mem_wdata/mem_rdata  bank interface
//   running                    high in RUN (also the phase debug view)
//   ld_overflow                sticky: load filled the bank without ld_last
//   if_misalign                sticky misaligned-fetch flag
// -----------------------------------------------------------------------------
module imem_ctrl
  import imem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              running,
  output logic              ld_overflow,
  output logic              if_misalign
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  imem_state_e       state, state_nxt;
  logic [ADDR_W-1:0] ld_cnt, ld_cnt_nxt;
  logic              ovf_nxt;
  logic              ld_acc;
  logic              run_en;
  logic              if_win, dbg_win;
  logic [SW-1:0]     starve_cnt;
  logic [ADDR_W-1:0] if_idx;
  logic              rd_pend;
  imem_src_e         rd_src;
  logic [DATA_W-1:0] if_rdata_q, dbg_rdata_q;

  // Outputs are forced quiet while rst_n is low, whatever phase we were in.
  assign ld_ready = (state == LOAD) && rst_n;
  assign run_en   = (state == RUN) && rst_n;
  assign running  = run_en;
  assign ld_acc   = ld_valid && ld_ready;
  assign if_idx   = if_addr[ADDR_W+1:2];

  // ---------------- phase FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= LOAD;
      ld_cnt      <= '0;
      ld_overflow <= 1'b0;
    end else begin
      state       <= state_nxt;
      ld_cnt      <= ld_cnt_nxt;
      ld_overflow <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ld_cnt_nxt = ld_cnt;
    ovf_nxt    = ld_overflow;
    case (state)
      LOAD: begin
        if (ld_acc) begin
          // Counter saturates at the top word so a runaway load never wraps
          // back over index 0.
          if (ld_cnt != CNT_MAX) ld_cnt_nxt = ld_cnt + ADDR_W'(1);
          if (ld_last) begin
            state_nxt = RUN;
          end else if (ld_cnt == CNT_MAX) begin
            state_nxt = RUN;
            ovf_nxt   = 1'b1;
          end
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = LOAD;
    endcase
  end

  // ---------------- arbitration ----------------
  imem_rr_guard #(
    .STARVE_MAX (STARVE_MAX),
    .SW         (SW)
  ) u_guard (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (run_en),
    .if_req     (if_req),
    .dbg_req    (dbg_req),
    .if_win     (if_win),
    .dbg_win    (dbg_win),
    .starve_cnt (starve_cnt)
  );

  assign if_gnt    = if_win;
  assign dbg_gnt   = dbg_win;
  assign mem_we    = ld_acc;
  assign mem_re    = if_win || dbg_win;
  assign mem_wdata = ld_data;

  always_comb begin
    mem_addr = if_idx;
    if (state == LOAD) mem_addr = ld_cnt;
    else if (dbg_win)  mem_addr = dbg_addr;
  end

  // ---------------- read response steering ----------------
  // The tag remembers who owned last cycle's read; reset drops it so an
  // in-flight response never surfaces.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
      rd_src  <= SRC_IF;
    end else begin
      rd_pend <= mem_re;
      rd_src  <= dbg_win ? SRC_DBG : SRC_IF;
    end
  end

  assign if_rvalid  = rd_pend && (rd_src == SRC_IF) && rst_n;
  assign dbg_rvalid = rd_pend && (rd_src == SRC_DBG) && rst_n;

  // Bank data is only valid in the response cycle; the hold registers keep
  // each port's last word stable afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_rdata_q  <= '0;
      dbg_rdata_q <= '0;
    end else begin
      if (if_rvalid)  if_rdata_q  <= mem_rdata;
      if (dbg_rvalid) dbg_rdata_q <= mem_rdata;
    end
  end

  assign if_rdata  = if_rvalid  ? mem_rdata : if_rdata_q;
  assign dbg_rdata = dbg_rvalid ? mem_rdata : dbg_rdata_q;

  // ---------------- optional alignment check ----------------
`ifdef IMEM_CTRL_ALIGN_CHK_EN
  logic misalign_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (if_win && (if_addr[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end
  assign if_misalign = misalign_q;
`else
  assign if_misalign = 1'b0;
`endif

  // Fetch byte-address bits outside the word index are deliberately ignored.
  logic unused_bits;
  assign unused_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0], starve_cnt};

endmodule

// File: tb/tb_imem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_ctrl
// Bench for imem_ctrl: a behavioural bank model answers the mem_* port, a
// reference image of the bank plus a loss-run arbitration model predict
// grants and read data; expected read data is queued per port and popped by
// a monitor when the DUT presents rvalid.
// -----------------------------------------------------------------------------
module tb_imem_ctrl;

  localparam int AW    = 11;
  localparam int DW    = 32;
  localparam int SMAX  = 4;
  localparam int DEPTH = 2048;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          ld_valid, ld_last, ld_ready;
  logic [DW-1:0] ld_data;
  logic          if_req, if_gnt, if_rvalid;
  logic [31:0]   if_addr;
  logic [DW-1:0] if_rdata;
  logic          dbg_req, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_rdata;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          running, ld_overflow, if_misalign;

  imem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_gnt      (if_gnt),
    .if_rvalid   (if_rvalid),
    .if_rdata    (if_rdata),
    .dbg_req     (dbg_req),
    .dbg_addr    (dbg_addr),
    .dbg_gnt     (dbg_gnt),
    .dbg_rvalid  (dbg_rvalid),
    .dbg_rdata   (dbg_rdata),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .running     (running),
    .ld_overflow (ld_overflow),
    .if_misalign (if_misalign)
  );

  // Bank model: registered read, one cycle latency.
  logic [DW-1:0] bank [DEPTH];
  always @(posedge clk) begin
    if (mem_we) bank[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= bank[mem_addr];
  end

  // ---------------- reference model state ----------------
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] if_q[$];
  logic [DW-1:0] dbg_q[$];
  int  m_cnt;
  bit  m_running, m_overflow, m_misalign;
  int  losses;
  logic [DW-1:0] last_if, last_dbg, mon_exp;
  int  dbg_gnt_cnt;
  logic [DW-1:0] first_word;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("if_rvalid", if_rvalid, if_q.size() > 0);
      if (if_rvalid && if_q.size() > 0) begin
        mon_exp = if_q.pop_front();
        chk("if_rdata", if_rdata, mon_exp);
        last_if = mon_exp;
      end else if (!if_rvalid) begin
        chk("if_rdata_hold", if_rdata, last_if);
      end
      chk("dbg_rvalid", dbg_rvalid, dbg_q.size() > 0);
      if (dbg_rvalid && dbg_q.size() > 0) begin
        mon_exp = dbg_q.pop_front();
        chk("dbg_rdata", dbg_rdata, mon_exp);
        last_dbg = mon_exp;
      end else if (!dbg_rvalid) begin
        chk("dbg_rdata_hold", dbg_rdata, last_dbg);
      end
    end else begin
      chk("if_rvalid_in_reset", if_rvalid, 1'b0);
      chk("dbg_rvalid_in_reset", dbg_rvalid, 1'b0);
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start just after a rising edge and return just after one.
  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    if_q.delete();
    dbg_q.delete();
    ld_valid = 1'b1;
    ld_data  = $urandom;
    ld_last  = 1'b0;
    if_req   = 1'b1;
    if_addr  = $urandom;
    dbg_req  = 1'b1;
    dbg_addr = AW'($urandom);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("rst_ld_ready", ld_ready, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_re", mem_re, 1'b0);
      chk("rst_if_gnt", if_gnt, 1'b0);
      chk("rst_dbg_gnt", dbg_gnt, 1'b0);
      chk("rst_running", running, 1'b0);
      @(posedge clk);
      #1;
    end
    rst_n    = 1'b1;
    ld_valid = 1'b0;
    if_req   = 1'b0;
    dbg_req  = 1'b0;
    m_cnt = 0; m_running = 0; m_overflow = 0; m_misalign = 0; losses = 0;
    last_if = '0; last_dbg = '0;
    @(negedge clk);
    chk("post_rst_running", running, 1'b0);
    chk("post_rst_ld_ready", ld_ready, 1'b1);
    chk("post_rst_ld_overflow", ld_overflow, 1'b0);
    chk("post_rst_if_misalign", if_misalign, 1'b0);
    chk("post_rst_mem_we", mem_we, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [DW-1:0] d, input bit last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    if_req   = 1'($urandom_range(0, 1));
    if_addr  = $urandom;
    dbg_req  = 1'($urandom_range(0, 1));
    dbg_addr = AW'($urandom);
    @(negedge clk);
    chk("ld_ready", ld_ready, 1'b1);
    chk("ld_mem_we", mem_we, 1'b1);
    chk("ld_mem_addr", mem_addr, m_cnt);
    chk("ld_mem_wdata", mem_wdata, d);
    chk("ld_if_gnt", if_gnt, 1'b0);
    chk("ld_dbg_gnt", dbg_gnt, 1'b0);
    chk("ld_running", running, 1'b0);
    ref_mem[m_cnt] = d;
    if (last) begin
      m_running = 1;
    end else if (m_cnt == DEPTH - 1) begin
      m_running = 1;
      m_overflow = 1;
    end else begin
      m_cnt++;
    end
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic load_idle();
    ld_valid = 1'b0;
    @(negedge clk);
    chk("ld_idle_ready", ld_ready, 1'b1);
    chk("ld_idle_mem_we", mem_we, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycle(input bit ir, input logic [31:0] ia, input bit dr, input logic [AW-1:0] da);
    bit ew_if, ew_dbg;
    int idx;
    ew_if = 0;
    ew_dbg = 0;
    idx = int'((ia >> 2) % DEPTH);
    if_req   = ir;
    if_addr  = ia;
    dbg_req  = dr;
    dbg_addr = da;
    ld_valid = 1'($urandom_range(0, 1));
    ld_data  = $urandom;
    ld_last  = 1'($urandom_range(0, 1));
    // Debug gets through once it has lost SMAX contested cycles in a row.
    if (ir && dr) begin
      if (losses >= SMAX) begin ew_dbg = 1; losses = 0; end
      else begin ew_if = 1; losses++; end
    end else if (ir) begin
      ew_if = 1; losses = 0;
    end else if (dr) begin
      ew_dbg = 1; losses = 0;
    end else begin
      losses = 0;
    end
    @(negedge clk);
    chk("run_running", running, 1'b1);
    chk("run_ld_ready", ld_ready, 1'b0);
    chk("run_mem_we", mem_we, 1'b0);
    chk("run_ld_overflow", ld_overflow, m_overflow);
    chk("run_if_misalign", if_misalign, m_misalign);
    chk("if_gnt", if_gnt, ew_if);
    chk("dbg_gnt", dbg_gnt, ew_dbg);
    chk("mem_re", mem_re, ew_if | ew_dbg);
    if (ew_if)  chk("mem_addr_if", mem_addr, idx);
    if (ew_dbg) chk("mem_addr_dbg", mem_addr, da);
    if (dbg_gnt) dbg_gnt_cnt++;
`ifdef IMEM_CTRL_ALIGN_CHK_EN
    if (ew_if && (ia % 4 != 0)) m_misalign = 1;
`endif
    @(posedge clk);
    #1;
    if (ew_if)  if_q.push_back(ref_mem[idx]);
    if (ew_dbg) dbg_q.push_back(ref_mem[da]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      bank[i] = '0;
      ref_mem[i] = '0;
    end
    rst_n = 1'b0;
    ld_valid = 0; ld_data = '0; ld_last = 0;
    if_req = 0; if_addr = '0; dbg_req = 0; dbg_addr = '0;
    last_if = '0; last_dbg = '0;
    dbg_gnt_cnt = 0;
    @(posedge clk);
    #1;
    do_reset(2);

    // Boot load of a three-word program, then first fetch of word 2.
    load_word(32'h2002_0005, 0);
    load_word(32'h2003_0007, 0);
    load_idle();
    load_word(32'h0043_1820, 1);
    run_cycle(1, 32'h0000_0008, 0, '0);
    run_cycle(0, '0, 0, '0);

    // Both ports hammering: debug must get 1 of every SMAX+1 cycles.
    dbg_gnt_cnt = 0;
    for (int i = 0; i < 20; i++)
      run_cycle(1, {$urandom} & 32'hFFFF_E00C, 1, AW'($urandom_range(0, 2)));
    chk("starve_ratio_dbg_grants", dbg_gnt_cnt, 4);

    // Reset with a fetch in flight: response must be dropped.
    run_cycle(1, 32'h4, 0, '0);
    do_reset(1);

    // Reset mid-load at counter 10, then reload from index 0.
    for (int i = 0; i < 10; i++) load_word($urandom, 0);
    do_reset(1);
    for (int i = 0; i < 5; i++) load_word($urandom, i == 4);
    for (int i = 0; i < 150; i++)
      run_cycle(1'($urandom_range(0, 1)),
                ({$urandom} & 32'hFFFF_E000) | (32'($urandom_range(0, 15)) << 2),
                1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)));

    // Runaway load: fills every word without ld_last.
    do_reset(1);
    first_word = $urandom;
    load_word(first_word, 0);
    for (int i = 1; i < DEPTH; i++) load_word($urandom, 0);
    run_cycle(0, '0, 1, '0);
    if (dbg_q.size() > 0) chk("ovf_index0_intact", dbg_q[0], first_word);
    else chk("ovf_index0_queued", 0, 1);
    for (int i = 0; i < 200; i++)
      run_cycle(1'($urandom_range(0, 1)), {$urandom} & 32'hFFFF_FFFC,
                1'($urandom_range(0, 1)), AW'($urandom));

    // Misaligned fetch at byte 6 returns word 1; flag is sticky when enabled.
    run_cycle(1, 32'h0000_0006, 0, '0);
    run_cycle(0, '0, 0, '0);
    run_cycle(1, 32'h0000_0010, 1, AW'(3));
    run_cycle(0, '0, 0, '0);
    run_cycle(0, '0, 0, '0);

    chk("if_queue_drained", if_q.size(), 0);
    chk("dbg_queue_drained", dbg_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
